// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader.
// Reads a little-endian word count header, then writes N words to IMEM.
module imem_loader #(
   parameter int DEPTH = 128
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int IW = $clog2(DEPTH + 1);

   typedef enum logic [2:0] {
      IDLE, HDR, DATA, WRITE, DONE, ERR
   } state_t;

   state_t        state, state_nx;
   logic [1:0]    byte_cnt;
   logic [31:0]   n;
   logic [31:0]   n_nx;
   logic [IW-1:0] word_idx;
   logic          acc;
   logic          last_byte;
   logic          launch;

   assign acc       = in_valid && in_ready;
   assign last_byte = acc && (byte_cnt == 2'd3);
   assign n_nx      = {in_data, n[31:8]};
   assign mem_addr  = 32'(word_idx) << 2;

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state decode and state-derived outputs
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      mem_we   = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      launch   = 1'b0;
      unique case (state)
         IDLE, DONE, ERR: begin
            done = (state == DONE);
            err  = (state == ERR);
            if (start) begin
               launch   = 1'b1;
               state_nx = HDR;
            end
         end
         HDR: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (last_byte) begin
               if (n_nx == 32'd0 || n_nx > 32'(DEPTH)) state_nx = ERR;
               else                                     state_nx = DATA;
            end
         end
         DATA: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (last_byte) state_nx = WRITE;
         end
         WRITE: begin
            mem_we = 1'b1;
            busy   = 1'b1;
            if (32'(word_idx) + 32'd1 == n) state_nx = DONE;
            else                            state_nx = DATA;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Byte counter, header count, word assembly and word index
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         byte_cnt  <= '0;
         n         <= '0;
         word_idx  <= '0;
         mem_wdata <= '0;
      end else begin
         if (launch) begin
            byte_cnt <= '0;
            word_idx <= '0;
         end else if (acc) begin
            byte_cnt <= byte_cnt + 2'd1;
         end
         if (acc && state == HDR)  n         <= n_nx;
         if (acc && state == DATA) mem_wdata <= {in_data, mem_wdata[31:8]};
         if (state == WRITE)       word_idx  <= word_idx + IW'(1);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader.
// Expected writes are queued per load; a negedge monitor pops and compares.
module tb_imem_loader;

   localparam int DEPTH = 128;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        err;

   int total = 0;
   int bad = 0;
   int writes = 0;
   logic [63:0] sb[$];
   logic [31:0] words[$];

   imem_loader #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the head of the scoreboard
   always @(negedge clk) begin
      if (rstn && mem_we) begin
         logic [63:0] e;
         writes++;
         total++;
         if (in_ready) begin
            bad++;
            $display("FAIL wr_ready: got in_ready=1 want 0 at addr %0h",
                     mem_addr);
         end
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL wr_extra: got addr %0h data %0h want none",
                     mem_addr, mem_wdata);
         end else begin
            e = sb.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
               bad++;
               $display("FAIL wr_data: got %0h_%0h want %0h_%0h",
                        mem_addr, mem_wdata, e[63:32], e[31:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int maxgap);
      int gap;
      logic ok;
      int k;
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      in_valid = 1'b0;
      repeat (gap) tick();
      in_valid = 1'b1;
      in_data  = b;
      k = 0;
      do begin
         ok = in_ready;
         tick();
         k++;
      end while (!ok && k < 50);
      if (!ok) chk("hs_timeout", 64'(k), 64'(0));
      in_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [31:0] n, input int maxgap);
      for (int b = 0; b < 4; b++) send_byte(n[8*b +: 8], maxgap);
   endtask

   task automatic rand_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   // Reference: a valid load writes words[i] to byte address 4*i
   task automatic run_load(input string nm, input logic [31:0] n,
                           input int maxgap, input int poke);
      logic ok;
      int k;
      ok = (n != 0) && (n <= DEPTH);
      writes = 0;
      if (ok)
         for (int i = 0; i < int'(n); i++)
            sb.push_back({32'(i * 4), words[i]});
      pulse_start();
      chk({nm, "_busy"}, 64'(busy), 64'(1));
      chk({nm, "_clr"}, 64'({done, err}), 64'(0));
      send_hdr(n, maxgap);
      if (ok)
         for (int i = 0; i < int'(n); i++)
            for (int b = 0; b < 4; b++) begin
               send_byte(words[i][8*b +: 8], maxgap);
               if (i * 4 + b == poke) pulse_start();
            end
      k = 0;
      while (!(done || err) && k < 20) begin
         tick();
         k++;
      end
      tick();
      chk({nm, "_done"}, 64'(done), 64'(ok));
      chk({nm, "_err"}, 64'(err), 64'(!ok));
      chk({nm, "_idle"}, 64'(busy), 64'(0));
      chk({nm, "_nwr"}, 64'(writes), ok ? 64'(n) : 64'(0));
      chk({nm, "_sb"}, 64'(sb.size()), 64'(0));
   endtask

   initial begin
      #2;
      chk("rst_out", {in_ready, mem_we, busy, done, err, mem_addr, mem_wdata},
          '0);
      tick();
      rstn = 1'b1;
      tick();
      tick();
      chk("rst_idle", 64'({busy, in_ready}), 64'(0));

      words = '{32'h2000_0013, 32'h2401_0042};
      run_load("basic", 32'd2, 0, -1);

      run_load("rej0", 32'd0, 0, -1);
      run_load("rej129", 32'd129, 0, -1);

      rand_words(DEPTH);
      run_load("full", 32'(DEPTH), 0, -1);
      chk("full_addr", 64'(mem_addr), 64'(32'h200));

      for (int r = 0; r < 3; r++) begin
         int n;
         n = int'($urandom_range(10, 3));
         rand_words(n);
         run_load("stall", 32'(n), 5, -1);
      end

      rand_words(2);
      pulse_start();
      send_hdr(32'd2, 0);
      send_byte(8'hAA, 0);
      send_byte(8'h55, 0);
      rstn = 1'b0;
      #1;
      chk("mid_rst", {in_ready, mem_we, busy, done, err, mem_addr, mem_wdata},
          '0);
      writes = 0;
      repeat (3) tick();
      rstn = 1'b1;
      repeat (3) tick();
      chk("mid_nowr", 64'({writes[7:0], busy}), 64'(0));
      run_load("after_rst", 32'd2, 2, -1);

      rand_words(4);
      run_load("ign_start", 32'd4, 1, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning the instruction memory capacity in 32-bit words.
REQ-002 SHALL have port clk  input  1  the system clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  single-cycle pulse that begins a load.
REQ-005 SHALL have port in_valid  input  1  a byte is offered on in_data.
REQ-006 SHALL have port in_data  input  8  the byte of the input stream.
REQ-007 SHALL have port in_ready  output  1  the loader accepts the byte this cycle.
REQ-008 SHALL have port mem_we  output  1  the instruction memory write strobe.
REQ-009 SHALL have port mem_addr  output  32  the byte address, always word-aligned (bits [1:0] = 0).
REQ-010 SHALL have port mem_wdata  output  32  the instruction word to be written.
REQ-011 SHALL have port busy  output  1  a load is in progress; the CPU is held in reset while busy is high.
REQ-012 SHALL have port done  output  1  the last load completed successfully.
REQ-013 SHALL have port err  output  1  the last load was rejected.

Function
REQ-014 SHALL implement the states IDLE, HDR, DATA, WRITE, DONE and ERR.
REQ-015 SHALL transfer a byte only on a cycle where in_valid and in_ready are both high.
REQ-016 SHALL drive in_ready high only in HDR and DATA.
REQ-017 SHALL, when start is seen in IDLE, DONE or ERR, move to HDR on the next cycle, clear done and err, and clear the byte counter and word index.
REQ-018 SHALL ignore start while in HDR, DATA or WRITE.
REQ-019 SHALL, in HDR, accept 4 bytes little-endian (the first byte is bits [7:0]) to form a 32-bit word count N.
REQ-020 SHALL, after the 4th header byte, go to ERR if N == 0 or N > DEPTH, and go to DATA otherwise.
REQ-021 SHALL, in DATA, assemble 4 accepted bytes little-endian into mem_wdata and then go to WRITE.
REQ-022 SHALL, in WRITE, assert mem_we for exactly one cycle, with mem_addr = word_index*4 and in_ready low.
REQ-023 SHALL set mem_we high in the cycle immediately after the 4th byte of a word is accepted (1-cycle latency).
REQ-024 SHALL, after WRITE, increment word_index, and go to DONE if word_index reaches N, otherwise return to DATA.
REQ-025 SHALL hold mem_addr and mem_wdata stable during WRITE, and SHALL NOT assert mem_we in any other state.
REQ-026 SHALL drive busy high in HDR, DATA and WRITE, and low elsewhere.
REQ-027 SHALL assert done high in DONE and err high in ERR, each held until the next accepted start.
REQ-028 SHALL tolerate gaps in in_valid of any length: the partial word is retained and the state does not change.
REQ-029 SHALL compute word_index with enough width that word_index = DEPTH-1 gives mem_addr = (DEPTH-1)*4 with no wrap.
REQ-030 SHALL NOT write beyond word N-1.

Reset
REQ-031 SHALL, while rstn is low, go to IDLE immediately (asynchronously) with in_ready, mem_we, busy, done and err = 0, mem_addr = 0, mem_wdata = 0, and all counters = 0.
REQ-032 SHALL, on reset during any state, discard the partial header or word, issue no write, and start the next load only on a new start.

Verification
REQ-033 SHALL verify a basic load: start, header bytes 02 00 00 00, data bytes 13 00 00 20, then 42 00 01 24 -> two mem_we pulses, the first with addr 0x0 and wdata 0x20000013, the second with addr 0x4 and wdata 0x24010042; then done=1 and busy=0.
REQ-034 SHALL verify a rejected load: header 00 00 00 00 -> err=1, no mem_we; then header 81 00 00 00 (129 > DEPTH) -> err=1, no mem_we.
REQ-035 SHALL verify the full-depth boundary: N=128 with random words -> 128 writes, the last at addr 0x1FC, then done=1.
REQ-036 SHALL verify stall tolerance: in_valid toggled randomly with idle gaps of 0-5 cycles -> the written words match the reference stream, and in_ready=0 in every WRITE cycle.
REQ-037 SHALL verify reset mid-word: rstn pulsed low after 2 data bytes -> all outputs are 0 at once and no mem_we occurs; a new start and a full load then succeed from addr 0x0.
REQ-038 SHALL verify that start is ignored mid-load: start asserted in DATA -> the load continues unchanged and the final done=1.
